// File: rtl/power_integ_pkg.sv
// Shared types and arithmetic helpers for the power integrator.
// All wide arithmetic is done in 128 bits and cast down at the call site.
package power_integ_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH,
    DRAIN
  } state_t;

  localparam int unsigned WIDE_W = 128;
  typedef logic [WIDE_W-1:0] wide_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic wide_t umax(input int unsigned w);
    return (wide_t'(1) << w) - wide_t'(1);
  endfunction

  function automatic wide_t round_half_up(input wide_t p, input int unsigned cut);
    return (p + (wide_t'(1) << (cut - 1))) >> cut;
  endfunction

  function automatic logic over_u(input wide_t v, input int unsigned w);
    return v > umax(w);
  endfunction

  function automatic wide_t sat_u(input wide_t v, input int unsigned w);
    return over_u(v, w) ? umax(w) : v;
  endfunction

endpackage

// File: rtl/power_lane.sv
// One lane of the power path: square (stage 1), add + round (stage 2),
// clamp to OUT_W (stage 3). Runs freely; validity is tracked by the parent.
module power_lane
  import power_integ_pkg::*;
#(
  parameter int unsigned IN_W       = 32,
  parameter int unsigned OUT_W      = 53,
  parameter int unsigned LSB_CUTOFF = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  i_re,
  input  logic [IN_W-1:0]  i_im,
  output logic [OUT_W-1:0] o_pow,
  output logic             o_sat
);

  localparam int unsigned SQ_W = 2 * IN_W;
  localparam int unsigned P_W  = SQ_W + 1;
  localparam int unsigned R_W  = P_W - LSB_CUTOFF;

  logic signed [SQ_W-1:0] w_re_x;
  logic signed [SQ_W-1:0] w_im_x;
  logic        [P_W-1:0]  w_p;
  logic        [SQ_W-1:0] r_sq_re;
  logic        [SQ_W-1:0] r_sq_im;
  logic        [R_W-1:0]  r_rnd;

  // Sign-extend before squaring so the full-width product is exact.
  assign w_re_x = SQ_W'($signed(i_re));
  assign w_im_x = SQ_W'($signed(i_im));
  assign w_p    = P_W'(r_sq_re) + P_W'(r_sq_im);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sq_re <= '0;
      r_sq_im <= '0;
      r_rnd   <= '0;
      o_pow   <= '0;
      o_sat   <= 1'b0;
    end else begin
      r_sq_re <= SQ_W'(w_re_x * w_re_x);
      r_sq_im <= SQ_W'(w_im_x * w_im_x);
      r_rnd   <= R_W'(round_half_up(wide_t'(w_p), LSB_CUTOFF));
      o_pow   <= OUT_W'(sat_u(wide_t'(r_rnd), OUT_W));
      o_sat   <= over_u(wide_t'(r_rnd), OUT_W);
    end
  end

endmodule

// File: rtl/power_integrator.sv
// Per-bin power integration over num_avg frames, then streams the integrated
// spectrum out one beat (LANES bins) at a time under valid/ready.
module power_integrator
  import power_integ_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned IN_W       = 32,
  parameter int unsigned OUT_W      = 53,
  parameter int unsigned LSB_CUTOFF = 10,
  parameter int unsigned MAX_AVG    = 16,
  parameter int unsigned BINS       = 8192
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [$clog2(MAX_AVG):0]                      num_avg,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  input  logic [LANES*IN_W-1:0]                         s_re,
  input  logic [LANES*IN_W-1:0]                         s_im,
  output logic                                          m_valid,
  input  logic                                          m_ready,
  output logic [LANES*(OUT_W+$clog2(MAX_AVG))-1:0]      m_data,
  output logic [$clog2(BINS/LANES)-1:0]                 m_index,
  output logic                                          m_last,
  output logic                                          busy,
  output logic                                          sat_flag
);

  localparam int unsigned ACC_W = OUT_W + $clog2(MAX_AVG);
  localparam int unsigned BEATS = BINS / LANES;
  localparam int unsigned IW    = idx_w(BEATS);
  localparam int unsigned NW    = $clog2(MAX_AVG) + 1;
  localparam int unsigned DW    = LANES * ACC_W;

  state_t           r_state;
  logic [IW-1:0]    r_beat;
  logic [IW-1:0]    r_didx;
  logic [NW-1:0]    r_frame;
  logic [NW-1:0]    r_navg;
  logic             r_s_ready;
  logic             r_busy;
  logic             r_m_valid;
  logic             r_sat;

  // Pipeline bookkeeping: index i holds stage i+1 (1..5).
  logic [4:0]       r_v;
  logic [IW-1:0]    r_a [5];
  logic [3:0]       r_f;

  logic [OUT_W-1:0] w_pow  [LANES];
  logic [OUT_W-1:0] r_pow4 [LANES];
  logic [LANES-1:0] w_lsat;
  logic [LANES-1:0] w_asat;
  logic [DW-1:0]    r_rd;
  logic [DW-1:0]    r_wdata;
  logic [DW-1:0]    w_sum;
  logic [DW-1:0]    r_ram [BEATS];

  logic             w_xfer;
  logic             w_inflight;
  logic [IW-1:0]    w_raddr;
  logic [NW-1:0]    w_navg_in;

  assign w_xfer     = s_valid & r_s_ready;
  assign w_inflight = |r_v;
  assign w_navg_in  = (num_avg == '0)          ? NW'(1) :
                      (num_avg > NW'(MAX_AVG)) ? NW'(MAX_AVG) : num_avg;

  // In DRAIN the read port looks one beat ahead on acceptance, so the
  // registered read data is always the beat being presented.
  assign w_raddr = (r_state == DRAIN) ?
                   ((r_m_valid && m_ready) ? r_didx + IW'(1) : r_didx) : r_a[2];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    power_lane #(
      .IN_W       (IN_W),
      .OUT_W      (OUT_W),
      .LSB_CUTOFF (LSB_CUTOFF)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_re  (s_re[k*IN_W +: IN_W]),
      .i_im  (s_im[k*IN_W +: IN_W]),
      .o_pow (w_pow[k]),
      .o_sat (w_lsat[k])
    );
  end

  always_comb begin
    w_sum  = '0;
    w_asat = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (r_f[3]) begin
        w_sum[k*ACC_W +: ACC_W] = ACC_W'(r_pow4[k]);
      end else begin
        w_sum[k*ACC_W +: ACC_W] =
          ACC_W'(sat_u(wide_t'(r_rd[k*ACC_W +: ACC_W]) + wide_t'(r_pow4[k]), ACC_W));
        w_asat[k] = over_u(wide_t'(r_rd[k*ACC_W +: ACC_W]) + wide_t'(r_pow4[k]), ACC_W);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v     <= '0;
      r_f     <= '0;
      r_wdata <= '0;
      for (int unsigned i = 0; i < 5; i++) r_a[i] <= '0;
      for (int unsigned k = 0; k < LANES; k++) r_pow4[k] <= '0;
    end else begin
      r_v    <= {r_v[3:0], w_xfer};
      r_f    <= {r_f[2:0], (r_frame == '0)};
      r_a[0] <= r_beat;
      for (int unsigned i = 1; i < 5; i++) r_a[i] <= r_a[i-1];
      for (int unsigned k = 0; k < LANES; k++) r_pow4[k] <= w_pow[k];
      r_wdata <= w_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (r_v[4]) r_ram[r_a[4]] <= r_wdata;
    r_rd <= r_ram[w_raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_beat    <= '0;
      r_frame   <= '0;
      r_navg    <= '0;
      r_didx    <= '0;
      r_s_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_m_valid <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      if ((r_v[2] && (|w_lsat)) || (r_v[3] && (|w_asat))) r_sat <= 1'b1;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_navg    <= w_navg_in;
            r_sat     <= 1'b0;
            r_beat    <= '0;
            r_frame   <= '0;
            r_state   <= ACCUM;
            r_busy    <= 1'b1;
            r_s_ready <= 1'b1;
          end
        end
        ACCUM: begin
          if (w_xfer) begin
            if (r_beat == IW'(BEATS - 1)) begin
              r_beat <= '0;
              if (r_frame == r_navg - NW'(1)) begin
                r_frame   <= '0;
                r_state   <= FLUSH;
                r_s_ready <= 1'b0;
              end else begin
                r_frame <= r_frame + NW'(1);
              end
            end else begin
              r_beat <= r_beat + IW'(1);
            end
          end
        end
        FLUSH: begin
          if (!w_inflight) begin
            r_state   <= DRAIN;
            r_didx    <= '0;
            r_m_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (!r_m_valid) begin
            r_m_valid <= 1'b1;
          end else if (m_ready) begin
            if (r_didx == IW'(BEATS - 1)) begin
              r_didx    <= '0;
              r_m_valid <= 1'b0;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_didx <= r_didx + IW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready  = r_s_ready;
  assign busy     = r_busy;
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_valid ? r_rd : '0;
  assign m_index  = r_didx;
  assign m_last   = r_m_valid && (r_didx == IW'(BEATS - 1));
  assign sat_flag = r_sat;

endmodule

// File: tb/tb_power_integrator.sv
// Randomized bench for power_integrator: stimulus frames are held in arrays
// and the expected spectrum is computed from them with plain arithmetic.
module tb_power_integrator;

  localparam int unsigned LANES      = 4;
  localparam int unsigned IN_W       = 32;
  localparam int unsigned OUT_W      = 53;
  localparam int unsigned LSB_CUTOFF = 10;
  localparam int unsigned MAX_AVG    = 16;
  localparam int unsigned BINS       = 64;
  localparam int unsigned ACC_W      = OUT_W + $clog2(MAX_AVG);
  localparam int unsigned BEATS      = BINS / LANES;
  localparam int unsigned IW         = $clog2(BEATS);
  localparam int unsigned NW         = $clog2(MAX_AVG) + 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [NW-1:0]            num_avg;
  logic                     s_valid;
  logic                     s_ready;
  logic [LANES*IN_W-1:0]    s_re;
  logic [LANES*IN_W-1:0]    s_im;
  logic                     m_valid;
  logic                     m_ready;
  logic [LANES*ACC_W-1:0]   m_data;
  logic [IW-1:0]            m_index;
  logic                     m_last;
  logic                     busy;
  logic                     sat_flag;

  power_integrator #(
    .LANES      (LANES),
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .LSB_CUTOFF (LSB_CUTOFF),
    .MAX_AVG    (MAX_AVG),
    .BINS       (BINS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_avg  (num_avg),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_re     (s_re),
    .s_im     (s_im),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_index  (m_index),
    .m_last   (m_last),
    .busy     (busy),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic signed [IN_W-1:0] st_re [MAX_AVG][BINS];
  logic signed [IN_W-1:0] st_im [MAX_AVG][BINS];
  logic [ACC_W-1:0]       got   [BINS];
  logic [ACC_W-1:0]       exp_v [BINS];
  bit                     exp_sat;
  int idx_err, last_err, hold_err, sready_err, tmo;

  task automatic fill_const(input int nfr, input int re, input int im);
    for (int f = 0; f < nfr; f++)
      for (int b = 0; b < BINS; b++) begin
        st_re[f][b] = re;
        st_im[f][b] = im;
      end
  endtask

  task automatic fill_rand(input int nfr);
    for (int f = 0; f < nfr; f++)
      for (int b = 0; b < BINS; b++) begin
        if ($urandom_range(1) == 0) begin
          st_re[f][b] = $urandom;
          st_im[f][b] = $urandom;
        end else begin
          st_re[f][b] = $urandom_range(8191) - 4096;
          st_im[f][b] = $urandom_range(8191) - 4096;
        end
      end
  endtask

  // Spectrum expected after integrating nfr frames of st_re/st_im.
  task automatic model(input int nfr);
    logic signed [127:0] a, c;
    logic [127:0] p, r, acc, omax, amax;
    omax = (128'd1 << OUT_W) - 1;
    amax = (128'd1 << ACC_W) - 1;
    exp_sat = 0;
    for (int b = 0; b < BINS; b++) begin
      acc = 0;
      for (int f = 0; f < nfr; f++) begin
        a = st_re[f][b];
        c = st_im[f][b];
        p = a * a + c * c;
        r = (p + 128'(2 ** (LSB_CUTOFF - 1))) / 128'(2 ** LSB_CUTOFF);
        if (r > omax) begin r = omax; exp_sat = 1; end
        acc = acc + r;
        if (acc > amax) begin acc = amax; exp_sat = 1; end
      end
      exp_v[b] = acc[ACC_W-1:0];
    end
  endtask

  task automatic apply_reset();
    start = 0; s_valid = 0; m_ready = 0; num_avg = '0; s_re = '0; s_im = '0;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic start_run(input int navg);
    @(negedge clk);
    start = 1'b1;
    num_avg = NW'(navg);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int nbeats, input int vpct);
    int beat = 0;
    int cyc = 0;
    int fr, bn;
    bit xfer;
    while (beat < nbeats && cyc < 5000) begin
      s_valid = ($urandom_range(99) < vpct);
      fr = beat / BEATS;
      bn = beat % BEATS;
      for (int k = 0; k < LANES; k++) begin
        if (s_valid) begin
          s_re[k*IN_W +: IN_W] = st_re[fr][bn*LANES + k];
          s_im[k*IN_W +: IN_W] = st_im[fr][bn*LANES + k];
        end else begin
          s_re[k*IN_W +: IN_W] = $urandom;
          s_im[k*IN_W +: IN_W] = $urandom;
        end
      end
      xfer = s_valid && s_ready;
      @(negedge clk);
      cyc++;
      if (xfer) beat++;
    end
    s_valid = 1'b0;
    if (beat < nbeats) tmo++;
  endtask

  task automatic collect(input bit mr_toggle, input bit poke);
    int acc_n = 0;
    int cyc = 0;
    bit holding = 0;
    logic [LANES*ACC_W-1:0] hd;
    logic [IW-1:0] hi;
    logic hl;
    idx_err = 0; last_err = 0; hold_err = 0; sready_err = 0;
    for (int b = 0; b < BINS; b++) got[b] = 'x;
    while (acc_n < BEATS && cyc < 2000) begin
      m_ready = mr_toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      start = poke && (acc_n == 2);
      if (s_ready !== 1'b0) sready_err++;
      if (holding && (m_valid !== 1'b1 || m_data !== hd || m_index !== hi || m_last !== hl))
        hold_err++;
      holding = 0;
      if (m_valid === 1'b1) begin
        if (m_ready) begin
          if (m_index !== IW'(acc_n)) idx_err++;
          if (m_last !== (acc_n == BEATS - 1)) last_err++;
          for (int k = 0; k < LANES; k++) got[acc_n*LANES + k] = m_data[k*ACC_W +: ACC_W];
          acc_n++;
        end else begin
          hd = m_data; hi = m_index; hl = m_last; holding = 1;
        end
      end else if (m_last !== 1'b0) begin
        last_err++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    m_ready = 1'b0;
    if (acc_n < BEATS) tmo++;
  endtask

  task automatic do_run(input int navg, input int nfr, input int vpct, input bit mr_toggle,
                        input bit poke);
    tmo = 0;
    start_run(navg);
    feed(nfr * BEATS, vpct);
    collect(mr_toggle, poke);
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (s_ready !== 1'b0) begin n_mis++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    n_cmp++; if (m_valid !== 1'b0) begin n_mis++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (sat_flag !== 1'b0) begin n_mis++; $display("FAIL reset_sat: got %b want 0", sat_flag); end
    n_cmp++; if (m_data !== '0 || m_index !== '0 || m_last !== 1'b0) begin
      n_mis++; $display("FAIL reset_m_out: data %h idx %0d last %b want 0", m_data, m_index, m_last);
    end
  endtask

  task automatic test_rounding();
    apply_reset();
    for (int b = 0; b < BINS; b++) begin
      st_re[0][b] = (b % 3 == 0) ? 16 : (b % 3 == 1) ? 15 : 1024;
      st_im[0][b] = (b % 3 == 2) ? 0 : 16;
    end
    model(1);
    do_run(1, 1, 100, 0, 0);
    n_cmp++; if (tmo !== 0) begin n_mis++; $display("FAIL round_timeout: got %0d want 0", tmo); end
    n_cmp++; if (got[0] !== 1) begin n_mis++; $display("FAIL round_16_16: got %0d want 1", got[0]); end
    n_cmp++; if (got[1] !== 0) begin n_mis++; $display("FAIL round_15_16: got %0d want 0", got[1]); end
    n_cmp++; if (got[2] !== 1024) begin n_mis++; $display("FAIL round_1024_0: got %0d want 1024", got[2]); end
    for (int b = 0; b < BINS; b++) begin
      n_cmp++;
      if (got[b] !== exp_v[b]) begin n_mis++; $display("FAIL round_bin%0d: got %0d want %0d", b, got[b], exp_v[b]); end
    end
    n_cmp++; if (sat_flag !== 1'b0) begin n_mis++; $display("FAIL round_sat: got %b want 0", sat_flag); end
  endtask

  task automatic test_clamp();
    logic [ACC_W-1:0] omax;
    omax = ACC_W'((128'd1 << OUT_W) - 1);
    apply_reset();
    fill_const(1, 32'sh8000_0000, 32'sh8000_0000);
    model(1);
    do_run(1, 1, 100, 0, 0);
    n_cmp++; if (tmo !== 0) begin n_mis++; $display("FAIL clamp_timeout: got %0d want 0", tmo); end
    for (int b = 0; b < BINS; b++) begin
      n_cmp++;
      if (got[b] !== omax) begin n_mis++; $display("FAIL clamp_bin%0d: got %0d want %0d", b, got[b], omax); end
    end
    n_cmp++; if (sat_flag !== 1'b1) begin n_mis++; $display("FAIL clamp_sat: got %b want 1", sat_flag); end
  endtask

  task automatic test_integration();
    apply_reset();
    fill_const(4, 1024, 0);
    do_run(4, 4, 100, 0, 0);
    n_cmp++; if (tmo !== 0) begin n_mis++; $display("FAIL integ_timeout: got %0d want 0", tmo); end
    for (int b = 0; b < BINS; b++) begin
      n_cmp++;
      if (got[b] !== 4096) begin n_mis++; $display("FAIL integ_bin%0d: got %0d want 4096", b, got[b]); end
    end
    n_cmp++; if (idx_err !== 0) begin n_mis++; $display("FAIL integ_index: errors %0d want 0", idx_err); end
    n_cmp++; if (last_err !== 0) begin n_mis++; $display("FAIL integ_last: errors %0d want 0", last_err); end
    n_cmp++; if (sready_err !== 0) begin n_mis++; $display("FAIL integ_s_ready: errors %0d want 0", sready_err); end
    n_cmp++; if (sat_flag !== 1'b0) begin n_mis++; $display("FAIL integ_sat: got %b want 0", sat_flag); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL integ_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    for (int pass = 0; pass < 2; pass++) begin
      apply_reset();
      fill_rand(2);
      model(2);
      do_run(2, 2, (pass == 0) ? 100 : 50, pass == 1, 0);
      n_cmp++; if (tmo !== 0) begin n_mis++; $display("FAIL bp%0d_timeout: got %0d want 0", pass, tmo); end
      for (int b = 0; b < BINS; b++) begin
        n_cmp++;
        if (got[b] !== exp_v[b]) begin n_mis++; $display("FAIL bp%0d_bin%0d: got %0d want %0d", pass, b, got[b], exp_v[b]); end
      end
      n_cmp++; if (hold_err !== 0) begin n_mis++; $display("FAIL bp%0d_hold: errors %0d want 0", pass, hold_err); end
      n_cmp++; if (idx_err !== 0 || last_err !== 0) begin
        n_mis++; $display("FAIL bp%0d_seq: idx errors %0d last errors %0d want 0", pass, idx_err, last_err);
      end
      n_cmp++; if (sat_flag !== exp_sat) begin n_mis++; $display("FAIL bp%0d_sat: got %b want %b", pass, sat_flag, exp_sat); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    fill_const(4, 32'sh8000_0000, 32'sh8000_0000);
    tmo = 0;
    start_run(4);
    feed(2 * BEATS + 7, 100);
    n_cmp++; if (sat_flag !== 1'b1) begin n_mis++; $display("FAIL mid_sat_before: got %b want 1", sat_flag); end
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b0 || sat_flag !== 1'b0) begin
      n_mis++; $display("FAIL mid_async_rst: busy %b m_valid %b s_ready %b sat %b want 0", busy, m_valid, s_ready, sat_flag);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_const(1, 32, 0);
    do_run(1, 1, 100, 0, 0);
    n_cmp++; if (tmo !== 0) begin n_mis++; $display("FAIL mid_timeout: got %0d want 0", tmo); end
    for (int b = 0; b < BINS; b++) begin
      n_cmp++;
      if (got[b] !== 1) begin n_mis++; $display("FAIL mid_bin%0d: got %0d want 1", b, got[b]); end
    end
    n_cmp++; if (sat_flag !== 1'b0) begin n_mis++; $display("FAIL mid_sat_after: got %b want 0", sat_flag); end
  endtask

  task automatic test_num_avg_limits();
    apply_reset();
    fill_rand(1);
    model(1);
    do_run(0, 1, 100, 0, 0);
    n_cmp++; if (tmo !== 0) begin n_mis++; $display("FAIL navg0_timeout: got %0d want 0", tmo); end
    for (int b = 0; b < BINS; b++) begin
      n_cmp++;
      if (got[b] !== exp_v[b]) begin n_mis++; $display("FAIL navg0_bin%0d: got %0d want %0d", b, got[b], exp_v[b]); end
    end
    fill_rand(MAX_AVG);
    model(MAX_AVG);
    do_run(31, MAX_AVG, 100, 0, 1);
    n_cmp++; if (tmo !== 0) begin n_mis++; $display("FAIL navg31_timeout: got %0d want 0", tmo); end
    n_cmp++; if (sready_err !== 0) begin n_mis++; $display("FAIL navg31_s_ready: errors %0d want 0", sready_err); end
    for (int b = 0; b < BINS; b++) begin
      n_cmp++;
      if (got[b] !== exp_v[b]) begin n_mis++; $display("FAIL navg31_bin%0d: got %0d want %0d", b, got[b], exp_v[b]); end
    end
    n_cmp++; if (sat_flag !== exp_sat) begin n_mis++; $display("FAIL navg31_sat: got %b want %b", sat_flag, exp_sat); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || m_valid !== 1'b0) begin
      n_mis++; $display("FAIL drain_start_ignored: busy %b m_valid %b want 0", busy, m_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_rounding();
    test_clamp();
    test_integration();
    test_backpressure();
    test_reset_mid();
    test_num_avg_limits();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_mis);
    $fatal(1);
  end

endmodule

// File: doc/power_integrator.md
Name: power_integrator

Overview:
- Parametrised successor to the 4-lane power stage in the FFT post-processing chain.
- Takes LANES complex FFT bins per beat and computes |X|^2, rounded at LSB_CUTOFF and saturated to OUT_W.
- Integrates each bin's power over a run-time number of frames in an internal accumulator RAM.
- After the last frame, streams the integrated spectrum out under valid/ready backpressure; sits after the rfft decode stage.

Parameters:
- LANES, 4, complex bins per input/output beat (power of 2, >=1)
- IN_W, 32, signed width of each real/imag input
- OUT_W, 53, unsigned width of per-bin rounded power
- LSB_CUTOFF, 10, LSBs dropped with round-half-up (>=1)
- MAX_AVG, 16, maximum frames integrated (power of 2)
- BINS, 8192, bins per frame (multiple of LANES; BINS/LANES >= 8)
- ACC_W (localparam), OUT_W+$clog2(MAX_AVG), accumulator width
- BEATS (localparam), BINS/LANES

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches num_avg, arms integration (honoured in IDLE only)
- num_avg  in  $clog2(MAX_AVG)+1  frames to integrate, 1..MAX_AVG; 0 treated as 1, >MAX_AVG clamped to MAX_AVG
- s_valid  in  1  input beat valid
- s_ready  out  1  high only in ACCUM
- s_re  in  LANES*IN_W  signed real parts, lane k at [k*IN_W +: IN_W]
- s_im  in  LANES*IN_W  signed imaginary parts, same packing
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  LANES*ACC_W  integrated power, lane k = bin m_index*LANES+k
- m_index  out  $clog2(BEATS)  beat index of m_data
- m_last  out  1  high on final beat (m_index==BEATS-1)
- busy  out  1  high in ACCUM, FLUSH or DRAIN
- sat_flag  out  1  sticky: a power clamp or accumulator saturation occurred this run; cleared on start

Behaviour:
- All outputs reset to 0; states reset to IDLE; beat/frame counters reset to 0. RAM contents need no reset.
- FSM: IDLE -start-> ACCUM; ACCUM -last beat of frame num_avg accepted-> FLUSH; FLUSH -pipeline empty (last write retired)-> DRAIN; DRAIN -m_last accepted-> IDLE. start outside IDLE is ignored.
- Input: a beat transfers on s_valid&s_ready. Beats arrive in bin order; an internal beat counter is the RAM address and wraps at BEATS-1, incrementing frame_cnt. No bin index is input.
- Power path, per lane: p = re*re + im*im, unsigned 2*IN_W+1 bits. r = (p + 2^(LSB_CUTOFF-1)) >> LSB_CUTOFF. Clamp r to 2^OUT_W-1 and set sat_flag on clamp. Pipeline is 3 stages: multiply, add+round, clamp.
- Accumulate: read RAM[addr]. Frame 0 writes r, ignoring stale contents. Later frames write acc+r, saturating at 2^ACC_W-1 and setting sat_flag. RMW latency is < BEATS, so no address hazard; no forwarding needed.
- Latency is 5 cycles from input transfer to RAM write.
- FLUSH: s_ready=0; waits until all in-flight writes retire.
- DRAIN: RAM read with 1-cycle latency, prefetch-registered output. m_data/m_index/m_last are held stable while m_valid & !m_ready, and advance one beat per accepted transfer. Full throughput when m_ready=1: first m_valid within 2 cycles of entering DRAIN, then back-to-back.
- Gaps in s_valid stall the pipeline without data loss; counters advance only on transfer.
- Async reset mid-operation aborts the run: state returns to IDLE, m_valid=0, sat_flag=0. The next run's frame 0 overwrites the RAM.

Decomposition:
- Package power_integ_pkg: state enum (IDLE, ACCUM, FLUSH, DRAIN), width helper functions, rounding/saturation function.
- Sub-module power_lane: one lane of the 3-stage square/round/clamp pipeline, instantiated LANES times, with sat output.
- Accumulator RAM is an inferred simple dual-port array of BEATS x LANES*ACC_W.

Test Plan (BINS=64, LANES=4, LSB_CUTOFF=10 unless noted):
- Rounding, num_avg=1, all lanes: (re,im)=(16,16)->1; (15,16)->0; (1024,0)->1024. sat_flag=0.
- Clamp, num_avg=1: re=im=-2^31 -> lane output 2^53-1, sat_flag=1.
- Integration, num_avg=4, every bin (1024,0) each frame -> all 64 outputs 4096. m_last only on m_index=15. s_ready=0 from FLUSH onward.
- Backpressure: m_ready toggling 1-0-0-1 and s_valid random 50% -> identical outputs to the no-stall run; data held stable while stalled.
- Reset mid-ACCUM at frame 2 beat 7, then a new run with num_avg=1 and (32,0) -> outputs 1 (stale accumulation discarded); sat_flag=0.
- num_avg=0 and num_avg=31 -> behave as 1 and 16 frames; start pulse during DRAIN ignored.
